knight_move_collector: RTL and testbench

Sequencer that sits directly downstream of the `scanSpots` knight-target scanner and turns its per-direction answers into a complete move set for one knight. On `start` it latches a square, steps the scanner through all eight knight directions, and classifies each returned target as quiet, capture, or blocked by a friendly piece. It publishes 64-bit move and capture masks plus a move count to the move-selection logic.

---
 rtl/chess_pkg.sv | 42 ++++
 rtl/scanSpots.sv | 67 ++++++
 rtl/knight_move_collector.sv | 118 +++++++++++
 tb/tb_knight_move_collector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// chess_pkg
// Shared chess definitions for the move-generation slice:
//   - piece type codes and the colour bit position inside a 4-bit square code
//   - the eight knight direction codes driven to the scanner
//   - a square-index helper (index = row*8 + col, row 0 = top)
//   - the state enum of the knight move collector
package chess_pkg;

    localparam int SQ_BITS    = 6;
    localparam int COLOUR_BIT = 3;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] PAWN   = 3'd1;
    localparam logic [2:0] KNIGHT = 3'd2;
    localparam logic [2:0] BISHOP = 3'd3;
    localparam logic [2:0] ROOK   = 3'd4;
    localparam logic [2:0] QUEEN  = 3'd5;
    localparam logic [2:0] KING   = 3'd6;

    // Knight directions, named by the path taken (row 0 is the top edge)
    localparam logic [2:0] UPLEFTLEFT     = 3'd0;
    localparam logic [2:0] UPUPLEFT       = 3'd1;
    localparam logic [2:0] UPUPRIGHT      = 3'd2;
    localparam logic [2:0] UPRIGHTRIGHT   = 3'd3;
    localparam logic [2:0] RIGHTRIGHTDOWN = 3'd4;
    localparam logic [2:0] DOWNDOWNRIGHT  = 3'd5;
    localparam logic [2:0] DOWNDOWNLEFT   = 3'd6;
    localparam logic [2:0] LEFTLEFTDOWN   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } collector_state_t;

    function automatic logic [SQ_BITS-1:0] sq_index(input logic [2:0] row,
                                                    input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/scanSpots.sv
// scanSpots
// Registered knight-target scanner. For the current square and direction it
// returns, one cycle later, the target square and the piece type found there.
// When the jump would leave the board the target equals the current square.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   bigBoard[256]   board, 4 bits per square
//   scan_dir[3]     knight direction (chess_pkg order)
//   scan_pos[6]     current square
//   near_pos[6]     registered target square
//   near_piece[3]   registered target piece type (0 = empty)
module scanSpots
    import chess_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] bigBoard,
    input  logic [2:0]   scan_dir,
    input  logic [5:0]   scan_pos,
    output logic [5:0]   near_pos,
    output logic [2:0]   near_piece
);

    logic signed [4:0] d_row;
    logic signed [4:0] d_col;
    logic signed [4:0] t_row;
    logic signed [4:0] t_col;
    logic              on_board;
    logic [5:0]        target;

    // Translate the direction code into a row/column offset and check
    // whether the landing square is still on the 8x8 board.
    always_comb begin
        d_row = 5'sd0;
        d_col = 5'sd0;
        case (scan_dir)
            UPLEFTLEFT:     begin d_row = -5'sd1; d_col = -5'sd2; end
            UPUPLEFT:       begin d_row = -5'sd2; d_col = -5'sd1; end
            UPUPRIGHT:      begin d_row = -5'sd2; d_col =  5'sd1; end
            UPRIGHTRIGHT:   begin d_row = -5'sd1; d_col =  5'sd2; end
            RIGHTRIGHTDOWN: begin d_row =  5'sd1; d_col =  5'sd2; end
            DOWNDOWNRIGHT:  begin d_row =  5'sd2; d_col =  5'sd1; end
            DOWNDOWNLEFT:   begin d_row =  5'sd2; d_col = -5'sd1; end
            default:        begin d_row =  5'sd1; d_col = -5'sd2; end
        endcase
        t_row    = $signed({2'b00, scan_pos[5:3]}) + d_row;
        t_col    = $signed({2'b00, scan_pos[2:0]}) + d_col;
        on_board = (t_row >= 5'sd0) && (t_row <= 5'sd7) &&
                   (t_col >= 5'sd0) && (t_col <= 5'sd7);
        target   = sq_index(t_row[2:0], t_col[2:0]);
    end

    // Register the answer; off-board jumps report the current square back.
    always_ff @(posedge clk) begin
        if (reset) begin
            near_pos   <= 6'd0;
            near_piece <= EMPTY;
        end else if (on_board) begin
            near_pos   <= target;
            near_piece <= bigBoard[{target, 2'b00} +: 3];
        end else begin
            near_pos   <= scan_pos;
            near_piece <= EMPTY;
        end
    end

endmodule

// File: rtl/knight_move_collector.sv
// knight_move_collector
// Steps the scanSpots scanner through all eight knight directions for one
// square and builds the knight's move set.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             one-cycle request, accepted when not busy
//   square            knight square, latched on accept
//   bigBoard[256]     board, 4 bits per square, held stable while busy
//   scan_dir/scan_pos direction and square driven to the scanner
//   near_pos/piece    registered scanner answer
//   move_mask         legal target squares
//   capture_mask      targets holding an enemy piece
//   move_count        number of bits set in move_mask
//   busy, done        activity flag and one-cycle completion pulse
module knight_move_collector
    import chess_pkg::*;
#(
    parameter int SQ_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SQ_W-1:0] square,
    input  logic [255:0]    bigBoard,
    output logic [2:0]      scan_dir,
    output logic [SQ_W-1:0] scan_pos,
    input  logic [SQ_W-1:0] near_pos,
    input  logic [2:0]      near_piece,
    output logic [63:0]     move_mask,
    output logic [63:0]     capture_mask,
    output logic [3:0]      move_count,
    output logic            busy,
    output logic            done
);

    collector_state_t state;
    collector_state_t next_state;

    logic [2:0] dir_cnt;
    logic       mover_colour;
    logic       result_valid;
    logic       accept;
    logic       off_board;
    logic       target_colour;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. DONE already has busy low, so a new request can be
    // taken there directly, which gives a back-to-back spacing of ten edges.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (dir_cnt == LEFTLEFTDOWN) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    next_state = start ? SCAN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the state.
    always_comb begin
        busy   = (state == SCAN) || (state == DRAIN);
        done   = (state == DONE);
        accept = start && ((state == IDLE) || (state == DONE));
    end

    assign scan_dir = dir_cnt;

    // The scanner answers one cycle after a direction is driven, so the
    // valid flag is simply the SCAN state delayed by one cycle.
    assign off_board     = (near_pos == scan_pos);
    assign target_colour = bigBoard[{near_pos, 2'b11}];

    // Datapath: latch the request, step the direction counter, and fold each
    // scanner answer into the masks and the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_cnt      <= 3'd0;
            scan_pos     <= '0;
            mover_colour <= 1'b0;
            result_valid <= 1'b0;
            move_mask    <= 64'd0;
            capture_mask <= 64'd0;
            move_count   <= 4'd0;
        end else begin
            result_valid <= (state == SCAN);
            if (state == SCAN) begin
                dir_cnt <= dir_cnt + 3'd1;
            end
            if (accept) begin
                scan_pos     <= square;
                mover_colour <= bigBoard[{square, 2'b11}];
                dir_cnt      <= 3'd0;
                move_mask    <= 64'd0;
                capture_mask <= 64'd0;
                move_count   <= 4'd0;
            end else if (result_valid && !off_board) begin
                if (near_piece == EMPTY) begin
                    move_mask[near_pos] <= 1'b1;
                    move_count          <= move_count + 4'd1;
                end else if (target_colour != mover_colour) begin
                    move_mask[near_pos]    <= 1'b1;
                    capture_mask[near_pos] <= 1'b1;
                    move_count             <= move_count + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_knight_move_collector.sv
// tb_knight_move_collector
// Directed bench: the collector wired to the scanSpots scanner, driven with
// hand-worked board positions and checked against hand-computed masks.
module tb_knight_move_collector;
    import chess_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   square;
    logic [255:0] bigBoard;
    logic [2:0]   scan_dir;
    logic [5:0]   scan_pos;
    logic [5:0]   near_pos;
    logic [2:0]   near_piece;
    logic [63:0]  move_mask;
    logic [63:0]  capture_mask;
    logic [3:0]   move_count;
    logic         busy;
    logic         done;

    int vectors = 0;
    int misses  = 0;

    always #5 clk = ~clk;

    knight_move_collector #(.SQ_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .square       (square),
        .bigBoard     (bigBoard),
        .scan_dir     (scan_dir),
        .scan_pos     (scan_pos),
        .near_pos     (near_pos),
        .near_piece   (near_piece),
        .move_mask    (move_mask),
        .capture_mask (capture_mask),
        .move_count   (move_count),
        .busy         (busy),
        .done         (done)
    );

    scanSpots scanner (
        .clk        (clk),
        .reset      (reset),
        .bigBoard   (bigBoard),
        .scan_dir   (scan_dir),
        .scan_pos   (scan_pos),
        .near_pos   (near_pos),
        .near_piece (near_piece)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic putPiece(input int sq, input logic [3:0] code);
        bigBoard[sq*4 +: 4] = code;
    endtask

    // Pulses start for one edge (edge N); returns #1 after edge N.
    task automatic applyStimulus(input logic [5:0] sq);
        square = sq;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen, bounded.
    task automatic waitDone(output int cycles);
        cycles = 40;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    function automatic logic [63:0] bit64(input int idx);
        logic [63:0] one;
        one = 64'd1;
        return one << idx;
    endfunction

    int lat;
    int done_seen;
    int done_at;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        square   = 6'd0;
        bigBoard = '0;
        tick();
        tick();
        checkOutput("rst_busy",  64'(busy), 64'd0);
        checkOutput("rst_done",  64'(done), 64'd0);
        checkOutput("rst_move",  move_mask, 64'd0);
        checkOutput("rst_cap",   capture_mask, 64'd0);
        checkOutput("rst_count", 64'(move_count), 64'd0);
        checkOutput("rst_dir",   64'(scan_dir), 64'd0);
        checkOutput("rst_pos",   64'(scan_pos), 64'd0);
        reset = 1'b0;
        tick();

        // Empty board, white knight at 57
        putPiece(57, 4'h2);
        applyStimulus(6'd57);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_dir0", 64'(scan_dir), 64'd0);
        waitDone(lat);
        checkOutput("t1_lat",   64'(lat), 64'd9);
        checkOutput("t1_busy_done", 64'(busy), 64'd0);
        checkOutput("t1_move",  move_mask, bit64(40) | bit64(42) | bit64(51));
        checkOutput("t1_cap",   capture_mask, 64'd0);
        checkOutput("t1_count", 64'(move_count), 64'd3);
        tick();
        checkOutput("t1_done_pulse", 64'(done), 64'd0);
        checkOutput("t1_hold", move_mask, bit64(40) | bit64(42) | bit64(51));

        // Empty board, knight at 0 (mover square empty, treated as white)
        bigBoard = '0;
        applyStimulus(6'd0);
        waitDone(lat);
        checkOutput("t2_lat",   64'(lat), 64'd9);
        checkOutput("t2_move",  move_mask, bit64(10) | bit64(17));
        checkOutput("t2_count", 64'(move_count), 64'd2);
        tick();

        // Empty board, knight at 27: all eight targets
        putPiece(27, 4'h2);
        applyStimulus(6'd27);
        waitDone(lat);
        checkOutput("t3_move", move_mask,
                    bit64(10) | bit64(12) | bit64(17) | bit64(21) |
                    bit64(33) | bit64(37) | bit64(42) | bit64(44));
        checkOutput("t3_cap",   capture_mask, 64'd0);
        checkOutput("t3_count", 64'(move_count), 64'd8);
        tick();

        // White knight at 57, white pawn at 42, black rook at 51
        bigBoard = '0;
        putPiece(57, 4'h2);
        putPiece(42, 4'h1);
        putPiece(51, 4'hC);
        applyStimulus(6'd57);
        waitDone(lat);
        checkOutput("t4_move",  move_mask, bit64(40) | bit64(51));
        checkOutput("t4_cap",   capture_mask, bit64(51));
        checkOutput("t4_count", 64'(move_count), 64'd2);
        tick();

        // Black knight at 27 among mixed pieces: white on 10 and 44 are
        // captures, black on 17 is friendly
        bigBoard = '0;
        putPiece(27, 4'hA);
        putPiece(10, 4'h3);
        putPiece(44, 4'h5);
        putPiece(17, 4'h9);
        applyStimulus(6'd27);
        waitDone(lat);
        checkOutput("t5_move", move_mask,
                    bit64(10) | bit64(12) | bit64(21) |
                    bit64(33) | bit64(37) | bit64(42) | bit64(44));
        checkOutput("t5_cap",   capture_mask, bit64(10) | bit64(44));
        checkOutput("t5_count", 64'(move_count), 64'd7);
        tick();

        // Second start at start+4 is ignored: one done at start+9
        bigBoard = '0;
        putPiece(57, 4'h2);
        applyStimulus(6'd57);
        done_seen = 0;
        done_at   = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 4) begin
                square = 6'd0;
                start  = 1'b1;
            end
            tick();
            if (i == 4) start = 1'b0;
            if (done) begin
                done_seen++;
                done_at = i;
            end
        end
        checkOutput("t6_done_n",  64'(done_seen), 64'd1);
        checkOutput("t6_done_at", 64'(done_at), 64'd9);
        checkOutput("t6_move",    move_mask, bit64(40) | bit64(42) | bit64(51));
        checkOutput("t6_count",   64'(move_count), 64'd3);

        // Reset at start+5 discards the scan
        bigBoard = '0;
        applyStimulus(6'd27);
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("t7_busy",  64'(busy), 64'd0);
        checkOutput("t7_done",  64'(done), 64'd0);
        checkOutput("t7_move",  move_mask, 64'd0);
        checkOutput("t7_count", 64'(move_count), 64'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen++;
        end
        checkOutput("t7_no_done", 64'(done_seen), 64'd0);
        applyStimulus(6'd0);
        waitDone(lat);
        checkOutput("t7_lat",  64'(lat), 64'd9);
        checkOutput("t7_move", move_mask, bit64(10) | bit64(17));
        tick();

        // Back-to-back: second start accepted on the done cycle
        putPiece(57, 4'h2);
        applyStimulus(6'd57);
        waitDone(lat);
        checkOutput("t8_lat1", 64'(lat), 64'd9);
        bigBoard = '0;
        applyStimulus(6'd0);
        checkOutput("t8_cleared", move_mask, 64'd0);
        checkOutput("t8_busy",    64'(busy), 64'd1);
        waitDone(lat);
        checkOutput("t8_lat2",  64'(lat), 64'd9);
        checkOutput("t8_move",  move_mask, bit64(10) | bit64(17));
        checkOutput("t8_cap",   capture_mask, 64'd0);
        checkOutput("t8_count", 64'(move_count), 64'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
